// File: rtl/hm_pkg.sv
// hm_pkg: widths, byte lanes and loader states shared by imem, PC and the program loader.
package hm_pkg;
  localparam int IW = 22;
  localparam int AW = 8;
  localparam int DEPTH_DEF = 64;
  localparam int LANE_W = 8;
  // The third byte only carries the top IW-2*LANE_W bits; the rest is pad that must be zero.
  localparam int HI_W = IW - 2 * LANE_W;
  typedef enum logic [2:0] {IDLE, HDR, B0, B1, B2, WRITE, DONE, ERR} state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte stream in, instruction memory write port and status out.
interface imem_loader_if;
  logic                     start;
  logic [hm_pkg::LANE_W-1:0] byte_in;
  logic                     byte_valid;
  logic                     byte_ready;
  logic                     iwe;
  logic [hm_pkg::AW-1:0]    iwa;
  logic [hm_pkg::IW-1:0]    iwd;
  logic                     busy;
  logic                     done;
  logic                     err;
  modport master (output start, byte_in, byte_valid,
                  input byte_ready, iwe, iwa, iwd, busy, done, err);
  modport slave (input start, byte_in, byte_valid,
                 output byte_ready, iwe, iwa, iwd, busy, done, err);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs a counted byte stream into 22-bit words written to imem from address 0.
module imem_loader
  import hm_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input logic          CLK,
  input logic          RST_N,
  imem_loader_if.slave bus
);
  state_t              state_q, state_d;
  logic [AW-1:0]       n_q, n_d, addr_q, addr_d, iwa_q, iwa_d;
  logic [LANE_W-1:0]   lo_q, lo_d, mid_q, mid_d;
  logic [IW-1:0]       iwd_q, iwd_d;
  logic                acc, bad_cnt;
  assign acc     = bus.byte_valid && bus.byte_ready;
  assign bad_cnt = (bus.byte_in == '0) || ({1'b0, bus.byte_in} > 9'(DEPTH));
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    mid_d   = mid_q;
    iwa_d   = iwa_q;
    iwd_d   = iwd_q;
    case (state_q)
      IDLE, DONE, ERR: state_d = bus.start ? HDR : state_q;
      HDR: if (acc) begin
        state_d = bad_cnt ? ERR : B0;
        n_d     = bad_cnt ? n_q : AW'(bus.byte_in);
        addr_d  = '0;
      end
      B0: if (acc) begin
        lo_d    = bus.byte_in;
        state_d = B1;
      end
      B1: if (acc) begin
        mid_d   = bus.byte_in;
        state_d = B2;
      end
      // iwa/iwd only change here so they hold steady between write pulses.
      B2: if (acc) begin
        if (bus.byte_in[LANE_W-1:HI_W] != '0) state_d = ERR;
        else begin
          iwd_d   = {bus.byte_in[HI_W-1:0], mid_q, lo_q};
          iwa_d   = addr_q;
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = (addr_q == n_q - 1'b1) ? DONE : B0;
        addr_d  = (addr_q == n_q - 1'b1) ? addr_q : addr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      n_q     <= '0;
      addr_q  <= '0;
      lo_q    <= '0;
      mid_q   <= '0;
      iwa_q   <= '0;
      iwd_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      mid_q   <= mid_d;
      iwa_q   <= iwa_d;
      iwd_q   <= iwd_d;
    end
  end
  assign bus.byte_ready = state_q inside {HDR, B0, B1, B2};
  assign bus.busy       = state_q inside {HDR, B0, B1, B2, WRITE};
  assign bus.iwe        = state_q == WRITE;
  assign bus.done       = state_q == DONE;
  assign bus.err        = state_q == ERR;
  assign bus.iwa        = iwa_q;
  assign bus.iwd        = iwd_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scenarios for the program loader with a write logger.
module tb_imem_loader;
  import hm_pkg::*;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [AW-1:0] wa_q[$];
  logic [IW-1:0] wd_q[$];
  int            wt_q[$];
  logic [7:0] basic [7] = '{8'h02, 8'h34, 8'h12, 8'h01, 8'hFF, 8'hFF, 8'h3F};
  logic [AW-1:0] exp_a [2] = '{8'd0, 8'd1};
  logic [IW-1:0] exp_d [2] = '{22'h011234, 22'h3FFFFF};

  imem_loader_if bus();
  imem_loader #(.DEPTH(64)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (bus.iwe === 1'b1) begin
    wa_q.push_back(bus.iwa);
    wd_q.push_back(bus.iwd);
    wt_q.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, want finished");
    $fatal(1);
  end

  task automatic clear();
    wa_q.delete();
    wd_q.delete();
    wt_q.delete();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    while (bus.byte_ready !== 1'b1 && t < 20) begin
      @(negedge CLK);
      t++;
    end
    checks++;
    if (t == 20) begin
      errors++;
      $display("FAIL send_ready: byte_ready=%b for byte %h, want 1", bus.byte_ready, b);
    end
    @(negedge CLK);
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_end(input int lim, output int c);
    int t = 0;
    while (!(bus.done === 1'b1 || bus.err === 1'b1) && t < lim) begin
      @(negedge CLK);
      t++;
    end
    c = cyc;
    checks++;
    if (t == lim) begin
      errors++;
      $display("FAIL wait_end: done=%b err=%b after %0d cycles, want done or err", bus.done, bus.err, lim);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.byte_ready, bus.iwe, bus.busy, bus.done, bus.err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: ready/iwe/busy/done/err=%b, want 00000",
               {bus.byte_ready, bus.iwe, bus.busy, bus.done, bus.err});
    end
    checks++;
    if (bus.iwa !== '0 || bus.iwd !== '0) begin
      errors++;
      $display("FAIL reset_bus: iwa=%h iwd=%h, want 0 0", bus.iwa, bus.iwd);
    end
  endtask

  task automatic test_basic();
    int dc;
    clear();
    pulse_start();
    foreach (basic[i]) send(basic[i]);
    wait_end(50, dc);
    checks++;
    if (wa_q.size() != 2) begin
      errors++;
      $display("FAIL basic_count: %0d writes, want 2", wa_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= wa_q.size() || wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL basic_write%0d: size=%0d, want iwa=%h iwd=%h", i, wa_q.size(), exp_a[i], exp_d[i]);
      end
    end
    if (wt_q.size() >= 2) begin
      checks++;
      if (wt_q[1] - wt_q[0] != 4) begin
        errors++;
        $display("FAIL basic_spacing: %0d cycles, want 4", wt_q[1] - wt_q[0]);
      end
      checks++;
      if (dc - wt_q[1] != 1) begin
        errors++;
        $display("FAIL basic_done_lat: %0d cycles after write, want 1", dc - wt_q[1]);
      end
    end
    checks++;
    if ({bus.done, bus.busy, bus.err} !== 3'b100) begin
      errors++;
      $display("FAIL basic_status: done/busy/err=%b, want 100", {bus.done, bus.busy, bus.err});
    end
  endtask

  task automatic test_backpressure();
    int dc;
    clear();
    pulse_start();
    foreach (basic[i]) begin
      bus.byte_valid = 1'b0;
      @(negedge CLK);
      if (bus.busy === 1'b1 && bus.iwe === 1'b0) begin
        checks++;
        if (bus.byte_ready !== 1'b1) begin
          errors++;
          $display("FAIL bp_ready: byte_ready=%b during stall, want 1", bus.byte_ready);
        end
      end
      send(basic[i]);
    end
    wait_end(50, dc);
    checks++;
    if (wa_q.size() != 2) begin
      errors++;
      $display("FAIL bp_count: %0d writes, want 2", wa_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= wa_q.size() || wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL bp_write%0d: size=%0d, want iwa=%h iwd=%h", i, wa_q.size(), exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_header();
    int dc;
    logic [7:0] k8;
    logic [7:0] bad [2] = '{8'h00, 8'h41};
    foreach (bad[j]) begin
      clear();
      pulse_start();
      send(bad[j]);
      wait_end(20, dc);
      checks++;
      if ({bus.err, bus.done, bus.busy} !== 3'b100 || wa_q.size() != 0) begin
        errors++;
        $display("FAIL hdr_err_%h: err/done/busy=%b writes=%0d, want 100 and 0",
                 bad[j], {bus.err, bus.done, bus.busy}, wa_q.size());
      end
    end
    clear();
    pulse_start();
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL hdr_err_clear: err=%b after start, want 0", bus.err);
    end
    send(8'h40);
    for (int k = 0; k < 64; k++) begin
      k8 = 8'(k);
      send(k8);
      send(k8 ^ 8'hA5);
      send({2'b00, k8[5:0]});
    end
    wait_end(50, dc);
    checks++;
    if (wa_q.size() != 64 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL hdr_full_count: %0d writes done=%b, want 64 and 1", wa_q.size(), bus.done);
    end
    for (int k = 0; k < 64 && k < wa_q.size(); k++) begin
      k8 = 8'(k);
      checks++;
      if (wa_q[k] !== k8 || wd_q[k] !== {k8[5:0], k8 ^ 8'hA5, k8}) begin
        errors++;
        $display("FAIL hdr_full_word%0d: iwa=%h iwd=%h, want %h %h",
                 k, wa_q[k], wd_q[k], k8, {k8[5:0], k8 ^ 8'hA5, k8});
      end
    end
  endtask

  task automatic test_pad();
    int dc;
    clear();
    pulse_start();
    send(8'h01);
    send(8'h00);
    send(8'h00);
    send(8'h40);
    wait_end(20, dc);
    checks++;
    if (bus.err !== 1'b1 || wa_q.size() != 0) begin
      errors++;
      $display("FAIL pad_err: err=%b writes=%0d, want 1 and 0", bus.err, wa_q.size());
    end
    pulse_start();
    checks++;
    if ({bus.err, bus.busy} !== 2'b01) begin
      errors++;
      $display("FAIL pad_restart: err/busy=%b, want 01", {bus.err, bus.busy});
    end
    send(8'h01);
    send(8'h56);
    send(8'h34);
    send(8'h12);
    wait_end(20, dc);
    checks++;
    if (wa_q.size() != 1 || wa_q[0] !== 8'h00 || wd_q[0] !== 22'h123456 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL pad_reload: writes=%0d done=%b, want 1 write 00:123456 and done", wa_q.size(), bus.done);
    end
  endtask

  task automatic test_restart();
    int dc;
    clear();
    pulse_start();
    send(8'h01);
    pulse_start();
    checks++;
    if ({bus.busy, bus.byte_ready} !== 2'b11) begin
      errors++;
      $display("FAIL restart_ignore: busy/ready=%b, want 11", {bus.busy, bus.byte_ready});
    end
    send(8'h11);
    send(8'h22);
    send(8'h33);
    wait_end(20, dc);
    checks++;
    if (wa_q.size() != 1 || wd_q[0] !== 22'h332211 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL restart_first: writes=%0d done=%b, want 1 write 332211 and done", wa_q.size(), bus.done);
    end
    clear();
    pulse_start();
    checks++;
    if ({bus.done, bus.busy} !== 2'b01) begin
      errors++;
      $display("FAIL restart_done_clear: done/busy=%b, want 01", {bus.done, bus.busy});
    end
    send(8'h02);
    for (int i = 1; i <= 6; i++) send(8'(i));
    wait_end(30, dc);
    checks++;
    if (wa_q.size() != 2 || wa_q[0] !== 8'h00 || wd_q[0] !== 22'h030201 ||
        wa_q[1] !== 8'h01 || wd_q[1] !== 22'h060504) begin
      errors++;
      $display("FAIL restart_overwrite: writes=%0d, want 00:030201 01:060504", wa_q.size());
    end
  endtask

  task automatic test_reset_midload();
    int dc;
    clear();
    pulse_start();
    send(8'h02);
    send(8'hAA);
    send(8'hBB);
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({bus.byte_ready, bus.iwe, bus.busy, bus.done, bus.err} !== 5'b0 || bus.iwa !== '0 || bus.iwd !== '0) begin
      errors++;
      $display("FAIL midreset_async: flags=%b iwa=%h iwd=%h, want all 0",
               {bus.byte_ready, bus.iwe, bus.busy, bus.done, bus.err}, bus.iwa, bus.iwd);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    bus.byte_in = 8'h01;
    bus.byte_valid = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({bus.busy, bus.byte_ready} !== 2'b00 || wa_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_idle: busy/ready=%b writes=%0d, want 00 and 0",
               {bus.busy, bus.byte_ready}, wa_q.size());
    end
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    bus.byte_valid = 1'b0;
    send(8'h01);
    send(8'h0A);
    send(8'h0B);
    send(8'h0C);
    wait_end(20, dc);
    checks++;
    if (wa_q.size() != 1 || wa_q[0] !== 8'h00 || wd_q[0] !== 22'h0C0B0A || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL start_with_byte: writes=%0d done=%b, want 1 write 00:0C0B0A and done", wa_q.size(), bus.done);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge CLK);
    test_reset();
    RST_N = 1'b1;
    @(negedge CLK);
    test_reset();
    test_basic();
    test_backpressure();
    test_header();
    test_pad();
    test_restart();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program loader that fills the write-less instruction memory before the CPU runs. It receives a byte stream over a valid/ready handshake and packs every 3 bytes into one 22-bit instruction word. Each word is written at sequential addresses from 0, and `done` is raised as the CPU run enable (W_time role). It sits between the host/test byte source and the instruction memory write side.

Parameters:
IW, 22, instruction word width
AW, 8, instruction address width (matches PC)
DEPTH, 64, number of instruction memory words; legal word count is 1..DEPTH

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse that begins a load; sampled in IDLE, DONE, ERR
byte_in  input  8  stream data
byte_valid  input  1  byte_in valid
byte_ready  output  1  loader accepts byte_in this cycle
iwe  output  1  instruction memory write enable, one-cycle pulse per word
iwa  output  AW  instruction memory write address
iwd  output  IW  instruction memory write data
busy  output  1  load in progress (HDR..WRITE)
done  output  1  load complete; CPU run enable
err  output  1  load aborted by a format error

Behaviour:
- Transfer rule: a byte is accepted only on a rising CLK edge where byte_valid=1 and byte_ready=1. byte_ready is a registered function of state: 1 in HDR/B0/B1/B2, 0 elsewhere.
- Reset (RST_N=0, asynchronous): state=IDLE; iwe=0, iwa=0, iwd=0, busy=0, done=0, err=0, byte_ready=0; word counter and address cleared. Reset mid-load discards the partial word and issues no write.
- States:
  - IDLE: on start -> HDR.
  - HDR: accept count byte N. If N=0 or N>DEPTH -> ERR; else store N, addr=0 -> B0.
  - B0: accept byte into iwd[7:0] -> B1.
  - B1: accept byte into iwd[15:8] -> B2.
  - B2: accept byte. If byte[7:6]!=0 -> ERR with no write. Else iwd[21:16]=byte[5:0] -> WRITE.
  - WRITE: iwe=1 for exactly this cycle with iwa=addr. Next: if addr==N-1 -> DONE, else addr+1 -> B0.
  - DONE: done=1, held until next start. start -> HDR, clears done in the same edge.
  - ERR: err=1, held until next start. start -> HDR, clears err.
- Word packing: little-endian, byte0 is the LSB. IW bits above 21 do not exist; the pad bits of the third byte must be zero.
- Latency: iwe asserts in the cycle after the third byte is accepted. Minimum throughput is 4 cycles per word. Stalls (byte_valid=0) hold state indefinitely, with no timeout.
- iwa and iwd are registered and hold their last value between writes. iwe is never asserted outside WRITE.
- busy=1 in HDR, B0, B1, B2, WRITE. busy, done and err are mutually exclusive.
- start during busy is ignored.
- Simultaneous start and byte_valid in IDLE/DONE/ERR: only start acts; the byte is not accepted because byte_ready=0.
- Address wrap: impossible by construction (N<=DEPTH<=2^AW). N=DEPTH writes addresses 0..DEPTH-1 exactly.

Decomposition:
- Shared package `hm_pkg`:
  - IW and AW constants, shared with the instruction memory and the PC unit.
  - State enum: IDLE, HDR, B0, B1, B2, WRITE, DONE, ERR.
  - Byte-lane constants.
- Single module. No sub-module is warranted; the byte assembler is three register slices inside the FSM.

Test Plan:
- Basic load: start; stream 0x02, 0x34,0x12,0x01, 0xFF,0xFF,0x3F with valid held high -> iwe pulses at iwa=0 with iwd=0x011234 and at iwa=1 with iwd=0x3FFFFF, 4 cycles apart. done=1 one cycle after the second write; busy=0.
- Backpressure: same stream with byte_valid toggling 1/0 every cycle -> identical writes, none duplicated or dropped. byte_ready stays 1 in the B states.
- Header errors: count 0x00 -> err=1, no iwe. Count 0x41 with DEPTH=64 -> err=1, no iwe. Count 0x40 with 192 bytes -> 64 writes at addresses 0..63, then done.
- Pad error: count 0x01, bytes 0x00,0x00,0x40 -> err=1, iwe never asserted. A subsequent start plus a valid stream clears err and loads correctly.
- Reset mid-load: assert RST_N=0 asynchronously between B1 and B2 -> all outputs 0 immediately, no write. After release the FSM is IDLE and ignores bytes until start.
- Restart and ignore: start during busy -> no effect. start in DONE -> done falls on the next edge and a new load overwrites from address 0.
